// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the countdown timer controller.
package timer_pkg;

  localparam int unsigned StateW            = 3;
  localparam int unsigned TickDivDefault    = 50000000;
  localparam int unsigned AlarmTicksDefault = 5;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Request/strobe bundle between a timer controller and its user / digit chain.
interface timer_ctrl_if;
  import timer_pkg::*;

  logic              start;
  logic              stop;
  logic              clear;
  logic              zero_in;
  logic              loadn;
  logic              enable;
  logic              cnt_clrn;
  logic              tick;
  logic              running;
  logic              alarm;
  logic [StateW-1:0] state;

  modport master (
    output start, stop, clear, zero_in,
    input  loadn, enable, cnt_clrn, tick, running, alarm, state
  );

  modport slave (
    input  start, stop, clear, zero_in,
    output loadn, enable, cnt_clrn, tick, running, alarm, state
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while run is high, registered tick on wrap.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic clrn,
  input  logic run,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned      CntW   = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            tick_d, tick_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: sequences load/decrement/clear of an external digit chain.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TickDivDefault,
  parameter int unsigned ALARM_TICKS = AlarmTicksDefault
) (
  input logic         clock,
  input logic         clrn,
  timer_ctrl_if.slave tmr_io
);

  localparam int unsigned        AlarmW    = $clog2(ALARM_TICKS + 1);
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(ALARM_TICKS - 1);

  state_e            state_d, state_q;
  logic [AlarmW-1:0] alarm_cnt_d, alarm_cnt_q;
  logic              clr_q;
  logic              tick;
  logic              presc_run;
  logic              presc_clr;

  // Prescaler restarts from zero on every entry to RUN from LOAD, and on clear.
  assign presc_run = (state_q == StRun) || (state_q == StDone);
  assign presc_clr = tmr_io.clear || (state_q == StLoad);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock    (clock),
    .clrn     (clrn),
    .run      (presc_run),
    .sync_clr (presc_clr),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    if (tmr_io.clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (tmr_io.start) state_d = StLoad;
        StLoad:  state_d = StRun;
        StRun: begin
          // A tick cycle issues a decrement; zero_in is stale until the next cycle.
          if (tmr_io.stop) begin
            state_d = StPause;
          end else if (tmr_io.zero_in && !tick) begin
            state_d = StDone;
          end
        end
        StPause: if (tmr_io.start) state_d = StRun;
        StDone: begin
          if (tmr_io.start) begin
            state_d = StLoad;
          end else if (tick && (alarm_cnt_q == AlarmLast)) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (state_d != StDone) begin
      alarm_cnt_d = '0;
    end else if ((state_q == StDone) && tick) begin
      alarm_cnt_d = alarm_cnt_q + AlarmW'(1);
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q     <= StIdle;
      alarm_cnt_q <= '0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      clr_q       <= tmr_io.clear;
    end
  end

  assign tmr_io.loadn    = (state_q != StLoad);
  assign tmr_io.enable   = !((state_q == StRun) && tick);
  assign tmr_io.cnt_clrn = !clr_q;
  assign tmr_io.tick     = tick;
  assign tmr_io.running  = (state_q == StRun);
  assign tmr_io.alarm    = (state_q == StDone);
  assign tmr_io.state    = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4, ALARM_TICKS=3 and a modelled digit chain.
module tb_timer_ctrl;

  logic clock;
  logic clrn;
  int   n_chk;
  int   n_pass;
  int   load_val;
  logic [7:0] chain_q;

  timer_ctrl_if tmr_if ();

  timer_ctrl #(
    .TICK_DIV    (4),
    .ALARM_TICKS (3)
  ) dut (
    .clock  (clock),
    .clrn   (clrn),
    .tmr_io (tmr_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream digit chain: load on loadn, clear on cnt_clrn, decrement on enable low.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      chain_q <= '0;
    end else if (!tmr_if.cnt_clrn) begin
      chain_q <= '0;
    end else if (!tmr_if.loadn) begin
      chain_q <= 8'(load_val);
    end else if (!tmr_if.enable && (chain_q != 8'd0)) begin
      chain_q <= chain_q - 8'd1;
    end
  end

  assign tmr_if.zero_in = (chain_q == 8'd0);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Cycles until enable goes low, bounded.
  task automatic wait_pulse(output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (tmr_if.enable && k < 12);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"},    32'(tmr_if.state),    32'd0);
    check_val({tag, "_loadn"},    32'(tmr_if.loadn),    32'd1);
    check_val({tag, "_enable"},   32'(tmr_if.enable),   32'd1);
    check_val({tag, "_cnt_clrn"}, 32'(tmr_if.cnt_clrn), 32'd1);
    check_val({tag, "_tick"},     32'(tmr_if.tick),     32'd0);
    check_val({tag, "_running"},  32'(tmr_if.running),  32'd0);
    check_val({tag, "_alarm"},    32'(tmr_if.alarm),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int ticks;
    int len;
    int en_low;
    logic last_tick;

    n_chk = 0;
    n_pass = 0;
    load_val = 2;
    clrn = 1'b0;
    tmr_if.start = 1'b0;
    tmr_if.stop  = 1'b0;
    tmr_if.clear = 1'b0;

    #2;
    check_reset_outputs("rst");
    #10;
    clrn = 1'b1;
    cyc();

    // Load 2, count down, alarm for three ticks.
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.start = 1'b0;
    check_val("load_state", 32'(tmr_if.state), 32'd1);
    check_val("load_loadn", 32'(tmr_if.loadn), 32'd0);
    cyc();
    check_val("run_state", 32'(tmr_if.state), 32'd2);
    check_val("run_loadn", 32'(tmr_if.loadn), 32'd1);
    check_val("run_running", 32'(tmr_if.running), 32'd1);
    wait_pulse(k);
    check_val("first_pulse_dist", 32'(k), 32'd4);
    check_val("first_pulse_tick", 32'(tmr_if.tick), 32'd1);
    wait_pulse(k);
    check_val("second_pulse_dist", 32'(k), 32'd4);
    cyc();
    check_val("zero_eval_state", 32'(tmr_if.state), 32'd2);
    cyc();
    check_val("done_state", 32'(tmr_if.state), 32'd4);
    check_val("done_alarm", 32'(tmr_if.alarm), 32'd1);
    ticks = 0;
    len = 0;
    en_low = 0;
    last_tick = 1'b0;
    while (tmr_if.alarm && len < 40) begin
      if (tmr_if.tick) ticks++;
      if (!tmr_if.enable) en_low++;
      last_tick = tmr_if.tick;
      len++;
      cyc();
    end
    check_val("alarm_ticks", 32'(ticks), 32'd3);
    check_val("alarm_ends_on_tick", 32'(last_tick), 32'd1);
    check_val("alarm_no_enable_low", 32'(en_low), 32'd0);
    check_val("after_alarm_state", 32'(tmr_if.state), 32'd0);

    // Pause two edges after a tick, hold ten cycles, resume.
    load_val = 9;
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.start = 1'b0;
    cyc();
    wait_pulse(k);
    check_val("b_first_pulse_dist", 32'(k), 32'd4);
    cyc();
    tmr_if.stop = 1'b1;
    cyc();
    tmr_if.stop = 1'b0;
    check_val("pause_state", 32'(tmr_if.state), 32'd3);
    check_val("pause_running", 32'(tmr_if.running), 32'd0);
    en_low = 0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!tmr_if.enable) en_low++;
      if (tmr_if.tick) ticks++;
    end
    check_val("pause_no_enable_low", 32'(en_low), 32'd0);
    check_val("pause_no_tick", 32'(ticks), 32'd0);
    check_val("pause_hold_state", 32'(tmr_if.state), 32'd3);
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.start = 1'b0;
    check_val("resume_state", 32'(tmr_if.state), 32'd2);
    wait_pulse(k);
    check_val("resume_pulse_dist", 32'(k), 32'd2);

    // clear + stop + start together in RUN.
    cyc();
    tmr_if.clear = 1'b1;
    tmr_if.stop  = 1'b1;
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.clear = 1'b0;
    tmr_if.stop  = 1'b0;
    tmr_if.start = 1'b0;
    check_val("clr_state", 32'(tmr_if.state), 32'd0);
    check_val("clr_cnt_clrn", 32'(tmr_if.cnt_clrn), 32'd0);
    check_val("clr_loadn", 32'(tmr_if.loadn), 32'd1);
    cyc();
    check_val("clr_cnt_clrn_release", 32'(tmr_if.cnt_clrn), 32'd1);
    check_val("clr_no_loadn", 32'(tmr_if.loadn), 32'd1);
    check_val("clr_chain_zero", 32'(chain_q), 32'd0);
    tmr_if.stop = 1'b1;
    cyc();
    tmr_if.stop = 1'b0;
    check_val("idle_stop_ignored", 32'(tmr_if.state), 32'd0);

    // Zero loaded: LOAD, RUN, DONE back to back, then DONE + start restarts.
    load_val = 0;
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.start = 1'b0;
    check_val("z_load_state", 32'(tmr_if.state), 32'd1);
    check_val("z_load_enable", 32'(tmr_if.enable), 32'd1);
    cyc();
    check_val("z_run_state", 32'(tmr_if.state), 32'd2);
    check_val("z_run_enable", 32'(tmr_if.enable), 32'd1);
    cyc();
    check_val("z_done_state", 32'(tmr_if.state), 32'd4);
    check_val("z_done_enable", 32'(tmr_if.enable), 32'd1);
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.start = 1'b0;
    check_val("restart_state", 32'(tmr_if.state), 32'd1);
    check_val("restart_alarm", 32'(tmr_if.alarm), 32'd0);
    cyc();
    cyc();
    tmr_if.clear = 1'b1;
    cyc();
    tmr_if.clear = 1'b0;
    check_val("done_clear_state", 32'(tmr_if.state), 32'd0);

    // Asynchronous reset mid-RUN.
    load_val = 9;
    tmr_if.start = 1'b1;
    cyc();
    tmr_if.start = 1'b0;
    cyc();
    cyc();
    cyc();
    check_val("pre_async_state", 32'(tmr_if.state), 32'd2);
    #3;
    clrn = 1'b0;
    #1;
    check_reset_outputs("async");
    #3;
    clrn = 1'b1;
    cyc();
    cyc();
    check_val("post_rst_state", 32'(tmr_if.state), 32'd0);
    check_val("post_rst_loadn", 32'(tmr_if.loadn), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
